i2c_transaction_sequencer: RTL and testbench

I2C_TRANSACTION_SEQUENCER -- requirements
Module: i2c_transaction_sequencer

---
 rtl/i2c_pkg.sv | 21 ++
 rtl/i2c_byte_shifter.sv | 45 ++++
 rtl/i2c_transaction_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_i2c_transaction_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared command codes and FSM state encoding for the I2C transaction sequencer.
package i2c_pkg;

    localparam logic [4:0] I2C_CMD_IDLE          = 5'd0;
    localparam logic [4:0] I2C_CMD_START         = 5'd1;
    localparam logic [4:0] I2C_CMD_DATA_TRANSFER = 5'd2;
    localparam logic [4:0] I2C_CMD_CATCH_ACK     = 5'd3;
    localparam logic [4:0] I2C_CMD_STOP          = 5'd5;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_START     = 4'd1;
    localparam logic [3:0] ST_ADDR      = 4'd2;
    localparam logic [3:0] ST_ADDR_ACK  = 4'd3;
    localparam logic [3:0] ST_WRITE     = 4'd4;
    localparam logic [3:0] ST_WRITE_ACK = 4'd5;
    localparam logic [3:0] ST_READ      = 4'd6;
    localparam logic [3:0] ST_READ_ACK  = 4'd7;
    localparam logic [3:0] ST_STOP      = 4'd8;
    localparam logic [3:0] ST_DONE      = 4'd9;

endpackage

// File: rtl/i2c_byte_shifter.sv
// 8-bit MSB-first shift register with bit counter; serves address, write and read bytes.
module i2c_byte_shifter (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_load,
    input  logic [7:0] i_load_data,
    input  logic       i_sample,
    input  logic       i_sda,
    input  logic       i_shift,
    output logic       o_msb,
    output logic [7:0] o_data_next,
    output logic       o_last_bit
);

    logic [7:0] shift_q;
    logic [2:0] bit_cnt;
    logic       sample_q;
    logic       in_bit;

    // A sample and shift in the same cycle must use the fresh SDA value.
    assign in_bit      = i_sample ? i_sda : sample_q;
    assign o_msb       = shift_q[7];
    assign o_data_next = {shift_q[6:0], in_bit};
    assign o_last_bit  = (bit_cnt == 3'd7);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            shift_q  <= 8'h00;
            bit_cnt  <= 3'd0;
            sample_q <= 1'b0;
        end else if (i_load) begin
            shift_q  <= i_load_data;
            bit_cnt  <= 3'd0;
            sample_q <= 1'b0;
        end else begin
            if (i_sample)
                sample_q <= i_sda;
            if (i_shift) begin
                shift_q <= {shift_q[6:0], in_bit};
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

endmodule

// File: rtl/i2c_transaction_sequencer.sv
// I2C master transaction FSM driving an external SCL timing block.
// Optional watchdog enabled by defining I2C_SEQ_WATCHDOG_EN.
//
// state      | meaning
// IDLE       | waiting for i_start
// START      | SDA low, waiting for START hold
// ADDR       | shifting out {addr, rw}
// ADDR_ACK   | slave ACK slot after address
// WRITE      | shifting out a write byte
// WRITE_ACK  | slave ACK slot after write byte
// READ       | shifting in a read byte
// READ_ACK   | master ACK/NACK slot
// STOP       | SDA held low, then released
// DONE       | one-cycle completion pulse
module i2c_transaction_sequencer
    import i2c_pkg::*;
#(
    parameter logic [4:0] CMD_IDLE          = I2C_CMD_IDLE,
    parameter logic [4:0] CMD_START         = I2C_CMD_START,
    parameter logic [4:0] CMD_DATA_TRANSFER = I2C_CMD_DATA_TRANSFER,
    parameter logic [4:0] CMD_CATCH_ACK     = I2C_CMD_CATCH_ACK,
    parameter logic [4:0] CMD_STOP          = I2C_CMD_STOP,
    parameter int         STOP_HOLD_CYC     = 20,
    parameter int         TIMEOUT_CYC       = 4095
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [6:0] i_addr,
    input  logic       i_rw,
    input  logic [3:0] i_nbytes,
    input  logic [7:0] i_wdata,
    input  logic       i_sda,
    input  logic       i_t_hd_sta_done,
    input  logic       i_t_hd_dat_done,
    input  logic       i_t_catch_ack_done,
    input  logic       i_t_high_done,
    output logic [4:0] o_cmd_state,
    output logic       o_sda_low,
    output logic       o_busy,
    output logic       o_wdata_req,
    output logic [7:0] o_rdata,
    output logic       o_rdata_valid,
    output logic       o_done,
    output logic       o_nack,
    output logic       o_timeout
);

    localparam int STOP_W = $clog2(STOP_HOLD_CYC + 1);

    logic [3:0]        state, state_nxt;
    logic              entry;
    logic [6:0]        addr_q;
    logic              rw_q;
    logic [3:0]        bytes_left;
    logic              ack_sample;
    logic              ack_bit;
    logic [STOP_W-1:0] stop_cnt;
    logic              in_shift, in_ack;
    logic              to_hit;
    logic [7:0]        load_data;
    logic              sh_msb, sh_last;
    logic [7:0]        sh_data_next;

    assign in_shift      = (state == ST_ADDR) || (state == ST_WRITE) || (state == ST_READ);
    assign in_ack        = (state == ST_ADDR_ACK) || (state == ST_WRITE_ACK);
    assign ack_bit       = i_t_catch_ack_done ? i_sda : ack_sample;
    assign o_busy        = (state != ST_IDLE);
    assign o_done        = (state == ST_DONE);
    assign o_wdata_req   = (state == ST_WRITE) && entry;
    assign o_rdata_valid = (state == ST_READ_ACK) && entry;

    always_comb begin
        load_data = 8'h00;
        if (state == ST_ADDR)
            load_data = {addr_q, rw_q};
        else if (state == ST_WRITE)
            load_data = i_wdata;
    end

    i2c_byte_shifter u_shifter (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_load      (entry && in_shift),
        .i_load_data (load_data),
        .i_sample    ((state == ST_READ) && i_t_catch_ack_done),
        .i_sda       (i_sda),
        .i_shift     (in_shift && i_t_high_done),
        .o_msb       (sh_msb),
        .o_data_next (sh_data_next),
        .o_last_bit  (sh_last)
    );

`ifdef I2C_SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_cnt;
    logic            wd_active;

    assign wd_active = (state != ST_IDLE) && (state != ST_STOP) && (state != ST_DONE);
    assign to_hit    = wd_active && (wd_cnt == WD_W'(TIMEOUT_CYC));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wd_cnt    <= '0;
            o_timeout <= 1'b0;
        end else begin
            if ((state_nxt != state) || i_t_high_done)
                wd_cnt <= '0;
            else if (wd_active)
                wd_cnt <= wd_cnt + 1'b1;
            if ((state == ST_IDLE) && i_start)
                o_timeout <= 1'b0;
            else if (to_hit)
                o_timeout <= 1'b1;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CYC == 0);
    assign to_hit     = 1'b0;
    assign o_timeout  = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        if (to_hit) begin
            state_nxt = ST_STOP;
        end else begin
            case (state)
                ST_IDLE:      if (i_start) state_nxt = ST_START;
                ST_START:     if (i_t_hd_sta_done) state_nxt = ST_ADDR;
                ST_ADDR:      if (i_t_high_done && sh_last) state_nxt = ST_ADDR_ACK;
                ST_WRITE:     if (i_t_high_done && sh_last) state_nxt = ST_WRITE_ACK;
                ST_READ:      if (i_t_high_done && sh_last) state_nxt = ST_READ_ACK;
                ST_ADDR_ACK, ST_WRITE_ACK: begin
                    if (i_t_high_done) begin
                        if (ack_bit || (bytes_left == 4'd0))
                            state_nxt = ST_STOP;
                        else
                            state_nxt = rw_q ? ST_READ : ST_WRITE;
                    end
                end
                ST_READ_ACK:  if (i_t_high_done) state_nxt = (bytes_left != 4'd0) ? ST_READ : ST_STOP;
                ST_STOP:      if ((stop_cnt == '0) && !o_sda_low) state_nxt = ST_DONE;
                ST_DONE:      state_nxt = ST_IDLE;
                default:      state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        case (state)
            ST_START:                              o_cmd_state = CMD_START;
            ST_ADDR, ST_WRITE, ST_READ:            o_cmd_state = CMD_DATA_TRANSFER;
            ST_ADDR_ACK, ST_WRITE_ACK, ST_READ_ACK: o_cmd_state = CMD_CATCH_ACK;
            ST_STOP:                               o_cmd_state = CMD_STOP;
            default:                               o_cmd_state = CMD_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            entry      <= 1'b0;
            addr_q     <= 7'd0;
            rw_q       <= 1'b0;
            bytes_left <= 4'd0;
            ack_sample <= 1'b0;
            stop_cnt   <= '0;
            o_sda_low  <= 1'b0;
            o_rdata    <= 8'h00;
            o_nack     <= 1'b0;
        end else begin
            state <= state_nxt;
            entry <= (state_nxt != state);
            if ((state == ST_IDLE) && i_start) begin
                addr_q     <= i_addr;
                rw_q       <= i_rw;
                bytes_left <= i_nbytes;
                o_nack     <= 1'b0;
            end
            if (in_ack && i_t_catch_ack_done)
                ack_sample <= i_sda;
            if (in_ack && i_t_high_done && ack_bit && !to_hit)
                o_nack <= 1'b1;
            if (state_nxt != state) begin
                case (state_nxt)
                    ST_START:                         o_sda_low <= 1'b1;
                    ST_ADDR_ACK, ST_WRITE_ACK, ST_READ: o_sda_low <= 1'b0;
                    ST_READ_ACK:                      o_sda_low <= (bytes_left != 4'd0);
                    ST_STOP: begin
                        o_sda_low <= 1'b1;
                        stop_cnt  <= STOP_W'(STOP_HOLD_CYC - 1);
                    end
                    default: ;
                endcase
                if ((state_nxt == ST_WRITE) || (state_nxt == ST_READ))
                    bytes_left <= bytes_left - 4'd1;
                if ((state == ST_READ) && !to_hit)
                    o_rdata <= sh_data_next;
            end else begin
                if (in_shift && (state != ST_READ) && i_t_hd_dat_done)
                    o_sda_low <= !sh_msb;
                // Hold-down counts out first; release gets its own cycle before DONE.
                if (state == ST_STOP) begin
                    if (stop_cnt != '0)
                        stop_cnt <= stop_cnt - 1'b1;
                    else
                        o_sda_low <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_transaction_sequencer.sv
// Self-checking bench: acts as timing block and slave, checks wire bits, pulses and flags.
module tb_i2c_transaction_sequencer;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_start = 1'b0;
    logic [6:0] i_addr = 7'd0;
    logic       i_rw = 1'b0;
    logic [3:0] i_nbytes = 4'd0;
    logic [7:0] i_wdata;
    logic       i_sda = 1'b1;
    logic       i_t_hd_sta_done = 1'b0;
    logic       i_t_hd_dat_done = 1'b0;
    logic       i_t_catch_ack_done = 1'b0;
    logic       i_t_high_done = 1'b0;
    logic [4:0] o_cmd_state;
    logic       o_sda_low, o_busy, o_wdata_req, o_rdata_valid, o_done, o_nack, o_timeout;
    logic [7:0] o_rdata;

    i2c_transaction_sequencer dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_addr(i_addr), .i_rw(i_rw),
        .i_nbytes(i_nbytes), .i_wdata(i_wdata), .i_sda(i_sda),
        .i_t_hd_sta_done(i_t_hd_sta_done), .i_t_hd_dat_done(i_t_hd_dat_done),
        .i_t_catch_ack_done(i_t_catch_ack_done), .i_t_high_done(i_t_high_done),
        .o_cmd_state(o_cmd_state), .o_sda_low(o_sda_low), .o_busy(o_busy),
        .o_wdata_req(o_wdata_req), .o_rdata(o_rdata), .o_rdata_valid(o_rdata_valid),
        .o_done(o_done), .o_nack(o_nack), .o_timeout(o_timeout)
    );

    always #50 i_clk = ~i_clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Expected wire: per ACK/data slot, the command code, the master's SDA and the slave's SDA.
    int exp_cmd[$], exp_bit[$], slv_sda[$], exp_rdata[$];
    int obs_cmd[$], obs_bit[$], rd_seen[$];
    int exp_wreq, exp_nack, exp_to;
    int wreq_seen, done_cnt, stop_low, stop_len, last_nack, prev_cmd, prev_sda;
    bit mon_en = 1'b0;
    bit exp_busy = 1'b0;

    logic [7:0] wdata_arr [16];
    logic [3:0] widx;
    logic       widx_clr = 1'b0;
    assign i_wdata = wdata_arr[widx];
    always @(posedge i_clk)
        if (widx_clr) widx <= 4'd0;
        else if (o_wdata_req) widx <= widx + 4'd1;

    always @(negedge i_clk) if (mon_en) begin
        chk("busy", int'(o_busy), int'(exp_busy));
        if (!o_busy) begin
            chk("idle_sda", int'(o_sda_low), 0);
            chk("idle_cmd", int'(o_cmd_state), 0);
        end
        chk("cmd_legal", int'(o_cmd_state inside {5'd0, 5'd1, 5'd2, 5'd3, 5'd5}), 1);
        if (i_t_catch_ack_done && (o_cmd_state == 5'd2 || o_cmd_state == 5'd3)) begin
            obs_cmd.push_back(int'(o_cmd_state));
            obs_bit.push_back(int'(!o_sda_low));
        end
        if (o_wdata_req) begin
            wreq_seen++;
            chk("wreq_in_transfer", int'(o_cmd_state), 2);
        end
        if (o_rdata_valid) begin
            rd_seen.push_back(int'(o_rdata));
            if (exp_rdata.size() == 0) chk("rdata_extra", 1, 0);
            else chk("rdata", int'(o_rdata), exp_rdata.pop_front());
        end
        if (o_cmd_state == 5'd5 && o_sda_low) stop_low++;
        if (prev_cmd == 5 && o_cmd_state != 5'd5) begin
            stop_len = stop_low;
            chk("stop_then_done", int'(o_done), 1);
            chk("stop_released", prev_sda, 0);
        end
        if (o_done) begin
            done_cnt++;
            last_nack = int'(o_nack);
            chk("done_nack", int'(o_nack), exp_nack);
            chk("done_timeout", int'(o_timeout), exp_to);
            exp_busy = 1'b0;
        end
        prev_cmd = int'(o_cmd_state);
        prev_sda = int'(o_sda_low);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic strobe(input int which, input bit noise);
        tick(1 + $urandom_range(0, 2));
        case (which)
            0: i_t_hd_sta_done = 1'b1;
            1: i_t_hd_dat_done = 1'b1;
            2: i_t_catch_ack_done = 1'b1;
            default: i_t_high_done = 1'b1;
        endcase
        if (noise && $urandom_range(0, 3) == 0) begin
            i_start = 1'b1;
            i_addr = 7'($urandom);
            i_rw = 1'($urandom);
            i_nbytes = 4'($urandom);
            if (which != 0) i_t_hd_sta_done = 1'b1;
        end
        tick(1);
        {i_t_hd_sta_done, i_t_hd_dat_done, i_t_catch_ack_done, i_t_high_done} = 4'b0;
        i_start = 1'b0;
    endtask

    task automatic push_byte(input int cmd_bits, input logic [7:0] mbits, input logic [7:0] sbits);
        for (int i = 7; i >= 0; i--) begin
            exp_cmd.push_back(cmd_bits);
            exp_bit.push_back(int'(mbits[i]));
            slv_sda.push_back(int'(sbits[i]));
        end
    endtask

    task automatic push_ack(input int mbit, input int sbit);
        exp_cmd.push_back(3);
        exp_bit.push_back(mbit);
        slv_sda.push_back(sbit);
    endtask

    // nack_at: -1 none, 0 address NACK, k>0 slave NACKs write byte k.
    task automatic run_txn(input logic [6:0] addr, input logic rw, input int n,
                           input int nack_at, input int abort_slot, input bit noise);
        logic [7:0] d;
        exp_cmd.delete(); exp_bit.delete(); slv_sda.delete(); exp_rdata.delete();
        obs_cmd.delete(); obs_bit.delete(); rd_seen.delete();
        exp_wreq = 0; exp_nack = 0; exp_to = 0;
        wreq_seen = 0; done_cnt = 0; stop_low = 0; stop_len = -1; last_nack = -1;
        push_byte(2, {addr, rw}, 8'hFF);
        push_ack(1, (nack_at == 0) ? 1 : 0);
        if (nack_at == 0) exp_nack = 1;
        else begin
            for (int b = 0; b < n; b++) begin
                if (!rw) begin
                    exp_wreq++;
                    push_byte(2, wdata_arr[b], 8'hFF);
                    push_ack(1, (nack_at == b + 1) ? 1 : 0);
                    if (nack_at == b + 1) begin exp_nack = 1; break; end
                end else begin
                    d = 8'($urandom);
                    if (n == 3 && !noise) d = 8'(8'h11 * (b + 1));
                    exp_rdata.push_back(int'(d));
                    push_byte(2, 8'hFF, d);
                    push_ack((b == n - 1) ? 1 : 0, 1);
                end
            end
        end
        widx_clr = 1'b1;
        tick(1);
        widx_clr = 1'b0;
        i_addr = addr; i_rw = rw; i_nbytes = 4'(n); i_start = 1'b1;
        tick(1);
        i_start = 1'b0; exp_busy = 1'b1;
        i_addr = 7'($urandom); i_rw = 1'($urandom); i_nbytes = 4'($urandom);
        if (noise) begin
            strobe(3, 1'b0);
            strobe(2, 1'b0);
        end
        strobe(0, 1'b0);
        for (int k = 0; k < exp_cmd.size(); k++) begin
            if (k == abort_slot) begin
                strobe(1, noise);
                return;
            end
            strobe(1, noise);
            i_sda = 1'(slv_sda[k]);
            strobe(2, noise);
            strobe(3, noise);
            i_sda = 1'b1;
        end
        for (int c = 0; c < 400 && done_cnt == 0; c++) tick(1);
        tick(2);
        chk("done_once", done_cnt, 1);
        chk("serial_len", obs_bit.size(), exp_bit.size());
        for (int i = 0; i < obs_bit.size() && i < exp_bit.size(); i++) begin
            chk("serial_bit", obs_bit[i], exp_bit[i]);
            chk("serial_cmd", obs_cmd[i], exp_cmd[i]);
        end
        chk("wreq_count", wreq_seen, exp_wreq);
        chk("rdata_all_seen", exp_rdata.size(), 0);
        chk("stop_hold", stop_len, 20);
    endtask

    function automatic int obs_byte(input int s);
        int v = 0;
        if (s + 8 > obs_bit.size()) return -1;
        for (int i = 0; i < 8; i++) v = (v << 1) | obs_bit[s + i];
        return v;
    endfunction

    initial begin
        for (int i = 0; i < 16; i++) wdata_arr[i] = 8'($urandom);
        tick(3);
        @(negedge i_clk);
        chk("rst_cmd", int'(o_cmd_state), 0);
        chk("rst_sda", int'(o_sda_low), 0);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_flags", int'({o_wdata_req, o_rdata_valid, o_done, o_nack, o_timeout}), 0);
        chk("rst_rdata", int'(o_rdata), 0);
        tick(1);
        i_rst = 1'b0;
        prev_cmd = 0; prev_sda = 0;
        mon_en = 1'b1;

        // Write 0x50, two bytes, all ACKed
        wdata_arr[0] = 8'hA5; wdata_arr[1] = 8'h3C;
        run_txn(7'h50, 1'b0, 2, -1, -1, 1'b0);
        chk("wr_addr_byte", obs_byte(0), 8'hA0);
        chk("wr_byte0", obs_byte(9), 8'hA5);
        chk("wr_byte1", obs_byte(18), 8'h3C);
        chk("wr_wreq_lit", wreq_seen, 2);
        chk("wr_nack_lit", last_nack, 0);

        // Read 0x50, three bytes 0x11 0x22 0x33
        run_txn(7'h50, 1'b1, 3, -1, -1, 1'b0);
        chk("rd_count_lit", rd_seen.size(), 3);
        if (rd_seen.size() == 3) begin
            chk("rd_val0_lit", rd_seen[0], 8'h11);
            chk("rd_val1_lit", rd_seen[1], 8'h22);
            chk("rd_val2_lit", rd_seen[2], 8'h33);
        end
        chk("rd_mack0_lit", (obs_bit.size() > 35) ? obs_bit[17] : -1, 0);
        chk("rd_mack1_lit", (obs_bit.size() > 35) ? obs_bit[26] : -1, 0);
        chk("rd_mnack_lit", (obs_bit.size() > 35) ? obs_bit[35] : -1, 1);

        // Address NACK
        run_txn(7'h50, 1'b0, 2, 0, -1, 1'b0);
        chk("anack_wreq_lit", wreq_seen, 0);
        chk("anack_nack_lit", last_nack, 1);

        // Ping
        run_txn(7'h2B, 1'b0, 0, -1, -1, 1'b0);
        chk("ping_slots_lit", obs_bit.size(), 9);
        chk("ping_stop_lit", stop_len, 20);

        // Reset in WRITE bit 4 (bit 4 of 0xA5 is 0, so SDA is driven low)
        wdata_arr[0] = 8'hA5;
        run_txn(7'h50, 1'b0, 2, -1, 13, 1'b0);
        chk("mid_write_sda", int'(o_sda_low), 1);
        mon_en = 1'b0;
        i_rst = 1'b1;
        tick(1);
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("mrst_cmd", int'(o_cmd_state), 0);
        chk("mrst_sda", int'(o_sda_low), 0);
        chk("mrst_busy", int'(o_busy), 0);
        chk("mrst_flags", int'({o_wdata_req, o_rdata_valid, o_done, o_nack, o_timeout}), 0);
        chk("mrst_rdata", int'(o_rdata), 0);
        exp_busy = 1'b0; prev_cmd = 0; prev_sda = 0;
        mon_en = 1'b1;
        tick(1);
        run_txn(7'h3A, 1'b0, 1, -1, -1, 1'b0);

        // Randomised transactions with ignored strobes and ignored i_start
        for (int t = 0; t < 12; t++) begin
            logic rw;
            int n, na;
            rw = 1'($urandom);
            n = $urandom_range(0, 4);
            for (int i = 0; i < 16; i++) wdata_arr[i] = 8'($urandom);
            na = -1;
            if ($urandom_range(0, 3) == 0) na = 0;
            else if (!rw && n > 0 && $urandom_range(0, 2) == 0) na = $urandom_range(1, n);
            run_txn(7'($urandom), rw, n, na, -1, 1'b1);
        end

`ifdef I2C_SEQ_WATCHDOG_EN
        begin
            int ncyc = 0;
            done_cnt = 0; stop_low = 0; stop_len = -1;
            exp_nack = 0; exp_to = 1; exp_rdata.delete();
            i_addr = 7'h50; i_rw = 1'b0; i_nbytes = 4'd1; i_start = 1'b1;
            tick(1);
            i_start = 1'b0; exp_busy = 1'b1;
            strobe(0, 1'b0);
            while (ncyc < 5000) begin
                @(negedge i_clk);
                ncyc++;
                if (o_cmd_state == 5'd5) break;
            end
            chk("wd_cycles_to_stop", ncyc, 4097);
            chk("wd_timeout_flag", int'(o_timeout), 1);
            tick(1);
            for (int c = 0; c < 400 && done_cnt == 0; c++) tick(1);
            tick(2);
            chk("wd_done_once", done_cnt, 1);
            chk("wd_stop_hold", stop_len, 20);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #(100 * 90000);
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
